// File: rtl/mem_stage_sram_like_pkg.sv
// Shared widths and the EXE->MEM payload layout for the MEM stage.
package mem_stage_sram_like_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD   = 79;
    localparam int unsigned MS_TO_WS_BUS_WD   = 73;
    localparam int unsigned MS_FWD_BLK_BUS_WD = 42;

    // Most orphaned responses that can be outstanding at once.
    localparam int unsigned DISCARD_MAX    = 3;
    localparam int unsigned DISCARD_CNT_WD = $clog2(DISCARD_MAX + 1);

    // EXE->MEM payload; mem_req is the MSB (bit 78).
    typedef struct packed {
        logic        mem_req;
        logic        lb;
        logic        lbu;
        logic        lh;
        logic        lhu;
        logic        lw;
        logic        lwl;
        logic        lwr;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] exe_result;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks and extends bytes/halves from the returned word
// and produces the per-byte register write strobe (partial for lwl/lwr).
module mem_load_align (
    input  logic        lb,
    input  logic        lbu,
    input  logic        lh,
    input  logic        lhu,
    input  logic        lw,
    input  logic        lwl,
    input  logic        lwr,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    input  logic        gr_we,
    output logic [31:0] result,
    output logic [3:0]  strb
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select/extend the loaded value and the strobe for the instruction kind.
    always_comb begin
        shifted = word >> {addr, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr[1] ? word[31:16] : word[15:0];
        result  = word;
        strb    = {4{gr_we}};
        if (lb) begin
            result = {{24{byte_v[7]}}, byte_v};
        end else if (lbu) begin
            result = {24'b0, byte_v};
        end else if (lh) begin
            result = {{16{half_v[15]}}, half_v};
        end else if (lhu) begin
            result = {16'b0, half_v};
        end else if (lw) begin
            result = word;
        end else if (lwl) begin
            // Low bytes of the word land in the upper bytes of the register.
            result = word << {~addr, 3'b000};
            strb   = (4'b1111 << ~addr) & {4{gr_we}};
        end else if (lwr) begin
            // High bytes of the word land in the lower bytes of the register.
            result = shifted;
            strb   = (4'b1111 >> addr) & {4{gr_we}};
        end
    end

endmodule

// File: rtl/mem_stage_sram_like.sv
// MEM pipeline stage for a split-transaction SRAM-like data bus: holds each
// instruction until its data_ok, buffers read data while WB stalls, and drops
// responses owed to flushed instructions.
module mem_stage_sram_like
    import mem_stage_sram_like_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ws_allowin,
    output logic                         ms_allowin,
    input  logic                         es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
    output logic                         ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
    input  logic                         data_sram_data_ok,
    input  logic [31:0]                  data_sram_rdata,
    input  logic                         ms_flush,
    input  logic                         es_req_killed,
    output logic                         ms_discard_full,
    output logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus
);

    es_to_ms_t                 bus_r;
    logic                      ms_valid;
    logic                      rbuf_valid;
    logic [31:0]               rbuf_data;
    logic [DISCARD_CNT_WD-1:0] discard_cnt;
    logic [DISCARD_CNT_WD-1:0] discard_next;

    logic        discard_hit;
    logic        own_ok;
    logic        data_avail;
    logic [31:0] mem_word;
    logic        ms_ready_go;
    logic        ms_leave;
    logic        req_lost;
    logic [31:0] load_result;
    logic [3:0]  gr_strb;
    logic [31:0] final_result;
    logic        fwd_stall;
    logic [3:0]  fwd_valid;

    // Response routing and pipeline handshake.
    always_comb begin
        // Responses are in order, so any pending orphan owns this data_ok.
        discard_hit    = data_sram_data_ok && (discard_cnt != '0);
        own_ok         = data_sram_data_ok && (discard_cnt == '0) && ms_valid
                         && bus_r.mem_req && !rbuf_valid;
        data_avail     = rbuf_valid || own_ok;
        mem_word       = rbuf_valid ? rbuf_data : data_sram_rdata;
        ms_ready_go    = !bus_r.mem_req || data_avail;
        ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
        ms_leave       = ms_to_ws_valid && ws_allowin;
        // A flushed instruction still waiting leaves its response orphaned.
        req_lost       = ms_valid && bus_r.mem_req && !data_avail;
    end

    // Orphan counter: flush adds lost requests, each discarded data_ok retires one.
    always_comb begin
        discard_next = discard_cnt;
        if (ms_flush) begin
            discard_next = discard_next + DISCARD_CNT_WD'(req_lost)
                                        + DISCARD_CNT_WD'(es_req_killed);
        end
        if (discard_hit) begin
            discard_next = discard_next - DISCARD_CNT_WD'(1);
        end
    end

    mem_load_align u_load_align (
        .lb     (bus_r.lb),
        .lbu    (bus_r.lbu),
        .lh     (bus_r.lh),
        .lhu    (bus_r.lhu),
        .lw     (bus_r.lw),
        .lwl    (bus_r.lwl),
        .lwr    (bus_r.lwr),
        .addr   (bus_r.exe_result[1:0]),
        .word   (mem_word),
        .gr_we  (bus_r.gr_we),
        .result (load_result),
        .strb   (gr_strb)
    );

    // Output payloads towards WB and the ID forwarding network.
    always_comb begin
        final_result    = bus_r.res_from_mem ? load_result : bus_r.exe_result;
        fwd_valid       = {4{ms_valid}} & gr_strb;
        fwd_stall       = ms_valid && bus_r.res_from_mem && !data_avail;
        ms_to_ws_bus    = {gr_strb, bus_r.dest, final_result, bus_r.pc};
        ms_fwd_blk_bus  = {fwd_stall, fwd_valid, bus_r.dest, final_result};
        ms_discard_full = (discard_cnt == DISCARD_CNT_WD'(DISCARD_MAX));
    end

    // Stage valid and captured EXE payload.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
            bus_r    <= '0;
        end else if (ms_flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid) begin
                bus_r <= es_to_ms_t'(es_to_ms_bus);
            end
        end
    end

    // Read-data buffer for responses that arrive while WB is stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rbuf_valid <= 1'b0;
            rbuf_data  <= '0;
        end else if (ms_flush || ms_leave) begin
            rbuf_valid <= 1'b0;
        end else if (own_ok) begin
            rbuf_valid <= 1'b1;
            rbuf_data  <= data_sram_rdata;
        end
    end

    // Orphaned-response counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_cnt <= '0;
        end else begin
            discard_cnt <= discard_next;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_like.sv
// Self-checking bench for mem_stage_sram_like: directed scenarios plus a
// randomized run against a transaction-level model of the bus and the stage.
module tb_mem_stage_sram_like;
    import mem_stage_sram_like_pkg::*;

    localparam int OP_ALU = 0, OP_LB = 1, OP_LBU = 2, OP_LH = 3, OP_LHU = 4;
    localparam int OP_LW = 5, OP_LWL = 6, OP_LWR = 7, OP_SW = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [78:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [72:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_flush;
    logic        es_req_killed;
    logic        ms_discard_full;
    logic [41:0] ms_fwd_blk_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_sram_like dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_flush          (ms_flush),
        .es_req_killed     (es_req_killed),
        .ms_discard_full   (ms_discard_full),
        .ms_fwd_blk_bus    (ms_fwd_blk_bus)
    );

    function automatic logic [78:0] mk_bus(input int op, input logic [31:0] exe,
                                           input logic [4:0] dest, input logic [31:0] pc);
        logic [6:0] ld;
        logic       mem_req, res_mem, gr_we;
        ld = '0;
        if (op >= OP_LB && op <= OP_LWR) ld[7 - op] = 1'b1;
        mem_req = (op != OP_ALU);
        res_mem = (op >= OP_LB && op <= OP_LWR);
        gr_we   = (op != OP_SW);
        return {mem_req, ld, res_mem, gr_we, dest, exe, pc};
    endfunction

    // Architectural WB value: {strobe, result} for an op, address and memory word.
    function automatic logic [35:0] ref_wb(input int op, input logic [31:0] exe,
                                           input logic [31:0] word);
        int unsigned a, s;
        logic [31:0] b, h, r;
        a = exe % 4;
        b = (word >> (8 * a)) & 32'hFF;
        h = (word >> (16 * (a / 2))) & 32'hFFFF;
        s = 15;
        r = word;
        case (op)
            OP_ALU: r = exe;
            OP_LB:  r = (b > 127) ? (b | 32'hFFFFFF00) : b;
            OP_LBU: r = b;
            OP_LH:  r = (h > 32767) ? (h | 32'hFFFF0000) : h;
            OP_LHU: r = h;
            OP_LW:  r = word;
            OP_LWL: begin r = word << (8 * (3 - a)); s = (15 << (3 - a)) & 15; end
            OP_LWR: begin r = word >> (8 * a); s = 15 >> a; end
            OP_SW:  begin r = exe; s = 0; end
            default: ;
        endcase
        return {s[3:0], r};
    endfunction

    task automatic idle();
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ms_flush          = 1'b0;
        es_req_killed     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a cycle; afterwards it sits in MEM.
    task automatic send_inst(input logic [78:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        next_cycle();
        es_to_ms_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        repeat (2) next_cycle();
        checks++; if (ms_allowin !== 1'b1) begin errors++;
            $display("FAIL reset_allowin: got %b want 1", ms_allowin); end
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", ms_to_ws_valid); end
        checks++; if (ms_discard_full !== 1'b0) begin errors++;
            $display("FAIL reset_full: got %b want 0", ms_discard_full); end
        checks++; if (ms_fwd_blk_bus[41:37] !== 5'b0) begin errors++;
            $display("FAIL reset_fwd: got %b want 00000", ms_fwd_blk_bus[41:37]); end
        resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_lw_basic();
        send_inst(mk_bus(OP_LW, 32'h100, 5'd3, 32'hBFC0_0000));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++;
            $display("FAIL lw_valid: got %b want 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_bus !== {4'hF, 5'd3, 32'hDEADBEEF, 32'hBFC0_0000}) begin errors++;
            $display("FAIL lw_bus: got %h want %h", ms_to_ws_bus,
                     {4'hF, 5'd3, 32'hDEADBEEF, 32'hBFC0_0000}); end
        checks++; if (ms_allowin !== 1'b1) begin errors++;
            $display("FAIL lw_allowin: got %b want 1", ms_allowin); end
        next_cycle();
        idle();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++;
            $display("FAIL lw_one_cycle: got %b want 0", ms_to_ws_valid); end
        next_cycle();
    endtask

    task automatic test_lb_wb_stall();
        send_inst(mk_bus(OP_LB, 32'h103, 5'd7, 32'h0000_1000));
        ws_allowin = 1'b0;
        #2;
        checks++; if (ms_fwd_blk_bus[41] !== 1'b1) begin errors++;
            $display("FAIL lb_wait_stall: got %b want 1", ms_fwd_blk_bus[41]); end
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80123456;
        #2;
        checks++; if (ms_allowin !== 1'b0) begin errors++;
            $display("FAIL lb_allowin_stalled: got %b want 0", ms_allowin); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h5555_5555;
            #2;
            checks++; if (ms_fwd_blk_bus[41] !== 1'b0) begin errors++;
                $display("FAIL lb_buf_stall[%0d]: got %b want 0", i, ms_fwd_blk_bus[41]); end
            checks++; if (ms_fwd_blk_bus[31:0] !== 32'hFFFFFF80) begin errors++;
                $display("FAIL lb_buf_fwd[%0d]: got %h want ffffff80", i,
                         ms_fwd_blk_bus[31:0]); end
        end
        next_cycle();
        ws_allowin = 1'b1;
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[72:32] !== {4'hF, 5'd7, 32'hFFFFFF80})
        begin errors++;
            $display("FAIL lb_leave: got %b/%h want 1/%h", ms_to_ws_valid, ms_to_ws_bus[72:32],
                     {4'hF, 5'd7, 32'hFFFFFF80}); end
        next_cycle();
        idle();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++;
            $display("FAIL lb_gone: got %b want 0", ms_to_ws_valid); end
        next_cycle();
    endtask

    // lwl then lwr back to back, each answered in its first MEM cycle.
    task automatic test_lwl_lwr();
        send_inst(mk_bus(OP_LWL, 32'h1, 5'd1, 32'h10));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAABBCCDD;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk_bus(OP_LWR, 32'h2, 5'd2, 32'h14);
        #2;
        checks++; if (ms_to_ws_bus[72:32] !== {4'hC, 5'd1, 32'hCCDD0000}) begin errors++;
            $display("FAIL lwl: got %h want %h", ms_to_ws_bus[72:32], {4'hC, 5'd1, 32'hCCDD0000}); end
        next_cycle();
        es_to_ms_valid = 1'b0;
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++;
            $display("FAIL lwr_valid: got %b want 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_bus[72:32] !== {4'h3, 5'd2, 32'h0000AABB}) begin errors++;
            $display("FAIL lwr: got %h want %h", ms_to_ws_bus[72:32], {4'h3, 5'd2, 32'h0000AABB}); end
        next_cycle();
        idle();
    endtask

    task automatic test_flush_discard();
        send_inst(mk_bus(OP_LW, 32'h200, 5'd4, 32'h20));
        next_cycle();
        ms_flush      = 1'b1;
        es_req_killed = 1'b1;
        #2;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++;
            $display("FAIL flush_valid: got %b want 0", ms_to_ws_valid); end
        next_cycle();
        idle();
        #2;
        checks++; if (ms_allowin !== 1'b1) begin errors++;
            $display("FAIL flush_allowin: got %b want 1", ms_allowin); end
        send_inst(mk_bus(OP_LW, 32'h300, 5'd5, 32'h24));
        for (int i = 0; i < 2; i++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'hBAD0_0001 + i;
            #2;
            checks++; if (ms_to_ws_valid !== 1'b0 || ms_fwd_blk_bus[41] !== 1'b1) begin errors++;
                $display("FAIL drop[%0d]: got valid %b stall %b want 0 1", i, ms_to_ws_valid,
                         ms_fwd_blk_bus[41]); end
            next_cycle();
        end
        data_sram_rdata = 32'h12345678;
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[72:32] !== {4'hF, 5'd5, 32'h12345678})
        begin errors++;
            $display("FAIL after_drop: got %b/%h want 1/%h", ms_to_ws_valid, ms_to_ws_bus[72:32],
                     {4'hF, 5'd5, 32'h12345678}); end
        next_cycle();
        idle();
    endtask

    task automatic test_discard_full();
        send_inst(mk_bus(OP_LW, 32'h400, 5'd6, 32'h30));
        ms_flush = 1'b1;
        next_cycle();
        // MEM idle: flush + killed EXE request + discarded data_ok nets to zero.
        es_req_killed     = 1'b1;
        data_sram_data_ok = 1'b1;
        next_cycle();
        data_sram_data_ok = 1'b0;
        next_cycle();
        #2;
        checks++; if (ms_discard_full !== 1'b0) begin errors++;
            $display("FAIL full_at2: got %b want 0", ms_discard_full); end
        next_cycle();
        idle();
        #2;
        checks++; if (ms_discard_full !== 1'b1) begin errors++;
            $display("FAIL full_at3: got %b want 1", ms_discard_full); end
        data_sram_data_ok = 1'b1;
        next_cycle();
        data_sram_data_ok = 1'b0;
        #2;
        checks++; if (ms_discard_full !== 1'b0) begin errors++;
            $display("FAIL full_drain: got %b want 0", ms_discard_full); end
        data_sram_data_ok = 1'b1;
        repeat (2) next_cycle();
        data_sram_data_ok = 1'b0;
        send_inst(mk_bus(OP_LHU, 32'h402, 5'd8, 32'h34));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h9876_0000;
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0000_9876) begin
            errors++;
            $display("FAIL drained_lhu: got %b/%h want 1/00009876", ms_to_ws_valid,
                     ms_to_ws_bus[63:32]); end
        next_cycle();
        idle();
    endtask

    task automatic test_async_reset();
        send_inst(mk_bus(OP_LB, 32'h500, 5'd9, 32'h40));
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11;
        next_cycle();
        data_sram_data_ok = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin errors++;
            $display("FAIL areset_hs: got valid %b allowin %b want 0 1", ms_to_ws_valid,
                     ms_allowin); end
        checks++; if (ms_fwd_blk_bus[41:37] !== 5'b0) begin errors++;
            $display("FAIL areset_fwd: got %b want 00000", ms_fwd_blk_bus[41:37]); end
        next_cycle();
        resetn = 1'b1;
        idle();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++;
            $display("FAIL areset_after: got %b want 0", ms_to_ws_valid); end
        ms_flush      = 1'b1;
        es_req_killed = 1'b1;
        repeat (3) next_cycle();
        idle();
        #1;
        resetn = 1'b0;
        #1;
        checks++; if (ms_discard_full !== 1'b0) begin errors++;
            $display("FAIL areset_full: got %b want 0", ms_discard_full); end
        next_cycle();
        resetn = 1'b1;
        next_cycle();
    endtask

    // Randomized traffic against a model of the bus's in-order response queue
    // (1 = owed to the live MEM instruction, 0 = owed to a killed one).
    task automatic test_random();
        bit          q[$];
        bit          m_valid, m_have;
        int          m_op;
        logic [31:0] m_exe, m_pc, m_word;
        logic [4:0]  m_dest;
        bit          ws, dok, fl, kreq, esv, own, avail, ready, exp_v, exp_allow, lost;
        int          op, killed, kc;
        logic [31:0] rd, exe, pc, word;
        logic [4:0]  dest;
        logic [35:0] wb;
        m_valid = 0;
        m_have  = 0;
        m_op    = 0;
        m_exe   = '0;
        m_pc    = '0;
        m_word  = '0;
        m_dest  = '0;
        for (int n = 0; n < 3000; n++) begin
            killed = 0;
            foreach (q[i]) if (!q[i]) killed++;
            ws   = ($urandom_range(0, 3) != 0);
            dok  = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            rd   = $urandom;
            fl   = ($urandom_range(0, 19) == 0);
            own  = dok && q[0];
            avail = m_have || own;
            lost = m_valid && (m_op != OP_ALU) && !avail;
            kc   = killed - ((dok && !q[0]) ? 1 : 0);
            kreq = fl && (kc + int'(lost) + 1 <= DISCARD_MAX) && ($urandom_range(0, 1) == 1);
            esv  = ($urandom_range(0, 1) == 1);
            op   = $urandom_range(0, 8);
            if (killed == DISCARD_MAX) op = OP_ALU;
            exe  = $urandom;
            pc   = $urandom;
            dest = 5'($urandom);
            ws_allowin        = ws;
            data_sram_data_ok = dok;
            data_sram_rdata   = rd;
            ms_flush          = fl;
            es_req_killed     = kreq;
            es_to_ms_valid    = esv;
            es_to_ms_bus      = mk_bus(op, exe, dest, pc);
            #2;
            word      = m_have ? m_word : rd;
            wb        = ref_wb(m_op, m_exe, word);
            ready     = (m_op == OP_ALU) || avail;
            exp_v     = m_valid && ready && !fl;
            exp_allow = !m_valid || (ready && ws);
            checks++; if (ms_to_ws_valid !== exp_v) begin errors++;
                $display("FAIL rnd_valid@%0d: got %b want %b", n, ms_to_ws_valid, exp_v); end
            checks++; if (ms_allowin !== exp_allow) begin errors++;
                $display("FAIL rnd_allowin@%0d: got %b want %b", n, ms_allowin, exp_allow); end
            checks++; if (ms_discard_full !== (killed == DISCARD_MAX)) begin errors++;
                $display("FAIL rnd_full@%0d: got %b want %b", n, ms_discard_full,
                         killed == DISCARD_MAX); end
            checks++; if (ms_fwd_blk_bus[41] !== (m_valid && m_op >= OP_LB && m_op <= OP_LWR
                                                  && !avail)) begin errors++;
                $display("FAIL rnd_fwd_stall@%0d: got %b", n, ms_fwd_blk_bus[41]); end
            checks++; if (ms_fwd_blk_bus[40:37] !== (m_valid ? wb[35:32] : 4'h0)) begin errors++;
                $display("FAIL rnd_fwd_valid@%0d: got %b want %b", n, ms_fwd_blk_bus[40:37],
                         m_valid ? wb[35:32] : 4'h0); end
            if (exp_v && ws) begin
                checks++; if (ms_to_ws_bus !== {wb[35:32], m_dest, wb[31:0], m_pc}) begin
                    errors++;
                    $display("FAIL rnd_wb@%0d op%0d: got %h want %h", n, m_op, ms_to_ws_bus,
                             {wb[35:32], m_dest, wb[31:0], m_pc}); end
            end
            next_cycle();
            if (dok) void'(q.pop_front());
            if (own && !(exp_v && ws)) begin
                m_have = 1;
                m_word = rd;
            end
            if (fl) begin
                if (lost) foreach (q[i]) q[i] = 1'b0;
                if (kreq) q.push_back(1'b0);
                m_valid = 0;
                m_have  = 0;
            end else if (exp_v && ws) begin
                m_valid = 0;
                m_have  = 0;
            end
            if (esv && exp_allow && !fl) begin
                m_valid = 1;
                m_have  = 0;
                m_op    = op;
                m_exe   = exe;
                m_pc    = pc;
                m_dest  = dest;
                if (op != OP_ALU) q.push_back(1'b1);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_lb_wb_stall();
        test_lwl_lwr();
        test_flush_discard();
        test_discard_full();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
